// File: rtl/shift_reg_pkg.sv
// rtl/shift_reg_pkg.sv - shared mode and run-state types for the universal shift register
package shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN_R = 2'b01,
        RUN_L = 2'b10
    } run_state_t;

endpackage

// File: rtl/shift_run_ctr.sv
// rtl/shift_run_ctr.sv - shift-run FSM: counts same-direction shifts, pulses pass_done per full-width pass
module shift_run_ctr
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  mode_t         i_mode,
    output logic [CW-1:0] o_cnt,
    output logic          o_pass_done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    run_state_t    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_pass_done;

    run_state_t    w_state_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_pass_next;
    run_state_t    w_dir;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pass_next  = 1'b0;
        w_dir        = (i_mode == MODE_SHR) ? RUN_R : RUN_L;
        if (i_en) begin
            case (i_mode)
                MODE_SHR, MODE_SHL: begin
                    w_state_next = w_dir;
                    // Continuing run wraps to 0 on the WIDTH-th shift but stays in RUN_x
                    if (r_state == w_dir) begin
                        if (r_cnt == LAST) begin
                            w_cnt_next  = '0;
                            w_pass_next = 1'b1;
                        end else begin
                            w_cnt_next = r_cnt + CW'(1);
                        end
                    end else begin
                        w_cnt_next = CW'(1);
                    end
                end
                default: begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_pass_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_pass_done <= w_pass_next;
        end
    end

    assign o_cnt       = r_cnt;
    assign o_pass_done = r_pass_done;

endmodule

// File: rtl/shift_reg_universal.sv
// rtl/shift_reg_universal.sv - N-bit universal shift register (hold/shr/shl/load) with q/nq and run counter
// Optional feature macro: ROTATE_EN (rot=1 recirculates the shifted-out bit instead of ser_in).
module shift_reg_universal
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             ser_in,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] nq,
    output logic             ser_out,
    output logic [CW-1:0]    cnt,
    output logic             pass_done
);

    mode_t            w_mode;
    logic             w_fill_r;
    logic             w_fill_l;
    logic [WIDTH-1:0] w_q_next;
    logic             w_so_next;
    logic [WIDTH-1:0] r_q;
    logic             r_ser_out;

    assign w_mode = mode_t'(mode);

`ifdef ROTATE_EN
    assign w_fill_r = rot ? r_q[0]       : ser_in;
    assign w_fill_l = rot ? r_q[WIDTH-1] : ser_in;
`else
    logic w_unused_rot;
    assign w_unused_rot = rot;
    assign w_fill_r     = ser_in;
    assign w_fill_l     = ser_in;
`endif

    always_comb begin
        w_q_next  = r_q;
        w_so_next = r_ser_out;
        if (en) begin
            case (w_mode)
                MODE_SHR: begin
                    w_q_next  = {w_fill_r, r_q[WIDTH-1:1]};
                    w_so_next = r_q[0];
                end
                MODE_SHL: begin
                    w_q_next  = {r_q[WIDTH-2:0], w_fill_l};
                    w_so_next = r_q[WIDTH-1];
                end
                MODE_LOAD: w_q_next = d;
                default:   w_q_next = r_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q       <= '0;
            r_ser_out <= 1'b0;
        end else begin
            r_q       <= w_q_next;
            r_ser_out <= w_so_next;
        end
    end

    shift_run_ctr #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_run_ctr (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_en        (en),
        .i_mode      (w_mode),
        .o_cnt       (cnt),
        .o_pass_done (pass_done)
    );

    assign q       = r_q;
    assign nq      = ~r_q;
    assign ser_out = r_ser_out;

endmodule

// File: tb/tb_shift_reg_universal.sv
// tb/tb_shift_reg_universal.sv - scoreboard bench for shift_reg_universal with directed vectors
module tb_shift_reg_universal;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] d;
    logic       ser_in;
    logic       rot;
    logic [7:0] q;
    logic [7:0] nq;
    logic       ser_out;
    logic [3:0] cnt;
    logic       pass_done;

    typedef struct {
        int         due;
        logic [7:0] q;
        logic       so;
        logic [3:0] cnt;
        logic       pd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    shift_reg_universal #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .d         (d),
        .ser_in    (ser_in),
        .rot       (rot),
        .q         (q),
        .nq        (nq),
        .ser_out   (ser_out),
        .cnt       (cnt),
        .pass_done (pass_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            chk("q",         {24'd0, q},         {24'd0, e.q});
            chk("nq",        {24'd0, nq},        {24'd0, ~e.q});
            chk("ser_out",   {31'd0, ser_out},   {31'd0, e.so});
            chk("cnt",       {28'd0, cnt},       {28'd0, e.cnt});
            chk("pass_done", {31'd0, pass_done}, {31'd0, e.pd});
        end
    end

    task automatic step(input logic r, input logic ee, input logic [1:0] m, input logic [7:0] dd,
                        input logic si, input logic ro, input logic [7:0] eq, input logic eso,
                        input logic [3:0] ec, input logic epd);
        exp_t x;
        rst = r; en = ee; mode = m; d = dd; ser_in = si; rot = ro;
        x.due = cyc + 1; x.q = eq; x.so = eso; x.cnt = ec; x.pd = epd;
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    localparam logic [1:0] H = 2'b00, R = 2'b01, L = 2'b10, LD = 2'b11;

    initial begin
        rst = 1'b1; en = 1'b0; mode = H; d = '0; ser_in = 1'b0; rot = 1'b0;
        // reset
        step(1, 0, H, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        step(1, 1, LD, 8'hFF, 0, 0, 8'h00, 0, 0, 0);
        // load A5, shift right x8 with zero fill
        step(0, 1, LD, 8'hA5, 0, 0, 8'hA5, 0, 0, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h52, 1, 1, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h29, 0, 2, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h14, 1, 3, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h0A, 0, 4, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h05, 0, 5, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h02, 1, 6, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h01, 0, 7, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h00, 1, 0, 1);
        step(0, 1, H, 8'h00, 0, 0, 8'h00, 1, 0, 0);
        // load 81, shl x3, then shr x2 (direction change restarts run)
        step(0, 1, LD, 8'h81, 0, 0, 8'h81, 1, 0, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'h02, 1, 1, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'h04, 0, 2, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'h08, 0, 3, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h04, 0, 1, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h02, 0, 2, 0);
        // run interrupted by en=0 for 4 cycles, then completed
        step(0, 1, LD, 8'hFF, 0, 0, 8'hFF, 0, 0, 0);
        step(0, 1, R, 8'h00, 1, 0, 8'hFF, 1, 1, 0);
        step(0, 1, R, 8'h00, 1, 0, 8'hFF, 1, 2, 0);
        step(0, 1, R, 8'h00, 1, 0, 8'hFF, 1, 3, 0);
        for (int i = 0; i < 4; i++) step(0, 0, R, 8'h00, 0, 0, 8'hFF, 1, 3, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h7F, 1, 4, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h3F, 1, 5, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h1F, 1, 6, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h0F, 1, 7, 0);
        step(0, 1, R, 8'h00, 0, 0, 8'h07, 1, 0, 1);
        step(0, 0, R, 8'h00, 0, 0, 8'h07, 1, 0, 0);
        // load 3C, shl x5, reset mid-run
        step(0, 1, LD, 8'h3C, 0, 0, 8'h3C, 1, 0, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'h78, 0, 1, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'hF0, 0, 2, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'hE0, 1, 3, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'hC0, 1, 4, 0);
        step(0, 1, L, 8'h00, 0, 0, 8'h80, 1, 5, 0);
        step(1, 1, L, 8'h00, 0, 0, 8'h00, 0, 0, 0);
        // reset on what would be the 8th shift suppresses pass_done
        step(0, 1, LD, 8'hFF, 0, 0, 8'hFF, 0, 0, 0);
        for (int i = 1; i <= 7; i++) step(0, 1, L, 8'h00, 1, 0, 8'hFF, 1, 4'(i), 0);
        step(1, 1, L, 8'h00, 1, 0, 8'h00, 0, 0, 0);
        step(0, 1, H, 8'h00, 0, 0, 8'h00, 0, 0, 0);
`ifdef ROTATE_EN
        // rotate right x8 returns the single set bit to the LSB
        step(0, 1, LD, 8'h01, 0, 0, 8'h01, 0, 0, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h80, 1, 1, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h40, 0, 2, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h20, 0, 3, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h10, 0, 4, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h08, 0, 5, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h04, 0, 6, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h02, 0, 7, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h01, 0, 0, 1);
        step(0, 1, L, 8'h00, 0, 1, 8'h02, 0, 1, 0);
`else
        // rot is ignored: fill comes from ser_in
        step(0, 1, LD, 8'h01, 0, 0, 8'h01, 0, 0, 0);
        step(0, 1, R, 8'h00, 0, 1, 8'h00, 1, 1, 0);
        step(0, 1, L, 8'h80, 1, 1, 8'h01, 0, 1, 0);
`endif
        step(0, 1, H, 8'h00, 0, 0, q, ser_out, 0, 0);
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
